// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg : shared state encoding, default sample width and saturating abs
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package audio_pkg;

   localparam int DEFAULT_AUDIO_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_READ    = 2'd1,
      ST_PROC    = 2'd2,
      ST_PUBLISH = 2'd3
   } state_t;

   // x must already be sign-extended from its w-bit form; the most negative
   // w-bit value maps to 2^(w-1)-1 instead of wrapping back to itself.
   function automatic logic [63:0] sat_abs(input logic signed [63:0] x, input int w);
      logic signed [63:0] lim;
      lim = (64'sd1 <<< (w - 1)) - 64'sd1;
      if (x < -lim)
         return lim;
      else if (x < 64'sd0)
         return -x;
      return x;
   endfunction

endpackage

`default_nettype wire

// File: rtl/audio_in_level_reader_abs_max2.sv
// ---------------------------------------------------------------------------
// abs_max2 : registers max(|left|,|right|) with saturation when load is high
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module abs_max2
   import audio_pkg::*;
#(
   parameter int W = DEFAULT_AUDIO_DATA_WIDTH
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] left,
   input  logic [W-1:0] right,
   output logic [W-1:0] mag
);

   logic [W-1:0] mag_left;
   logic [W-1:0] mag_right;

   always_comb begin
      mag_left  = W'(sat_abs(64'($signed(left)), W));
      mag_right = W'(sat_abs(64'($signed(right)), W));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         mag <= '0;
      else if (load)
         mag <= (mag_left > mag_right) ? mag_left : mag_right;
   end

endmodule

`default_nettype wire

// File: rtl/audio_in_level_reader.sv
// ---------------------------------------------------------------------------
// audio_in_level_reader : drains the ADC FIFO, publishes per-window peak level
//                         and a holdoff-gated clap trigger
// Revision              : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module audio_in_level_reader
   import audio_pkg::*;
#(
   parameter int         AUDIO_DATA_WIDTH = DEFAULT_AUDIO_DATA_WIDTH,
   parameter int         WINDOW_SAMPLES   = 4800,
   parameter logic [7:0] THRESHOLD        = 8'h40,
   parameter int         HOLDOFF_WINDOWS  = 2
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        enable,
   input  logic                        audio_in_available,
   input  logic [AUDIO_DATA_WIDTH-1:0] left_in,
   input  logic [AUDIO_DATA_WIDTH-1:0] right_in,
   output logic                        read_audio_in,
   output logic [7:0]                  peak_level,
   output logic                        level_valid,
   output logic                        clap_pulse,
   output logic                        holdoff_active
);

   localparam int W      = AUDIO_DATA_WIDTH;
   localparam int CNT_W  = $clog2(WINDOW_SAMPLES);
   localparam int HOLD_W = (HOLDOFF_WINDOWS < 1) ? 1 : $clog2(HOLDOFF_WINDOWS + 1);
   localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(WINDOW_SAMPLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_WINDOWS);

   state_t              state;
   logic [W-1:0]        running_peak;
   logic [W-1:0]        sample_mag;
   logic [W-1:0]        new_peak;
   logic [7:0]          new_level;
   logic [CNT_W-1:0]    sample_cnt;
   logic [HOLD_W-1:0]   holdoff;
   logic                drop_sample;
   logic                load_sample;

   assign load_sample = (state == ST_READ);

   abs_max2 #(.W(W)) u_abs_max2 (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load_sample),
      .left    (left_in),
      .right   (right_in),
      .mag     (sample_mag)
   );

   always_comb begin
      new_peak  = (sample_mag > running_peak) ? sample_mag : running_peak;
      new_level = new_peak[W-2 -: 8];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= ST_IDLE;
         running_peak   <= '0;
         sample_cnt     <= '0;
         holdoff        <= '0;
         drop_sample    <= 1'b0;
         read_audio_in  <= 1'b0;
         peak_level     <= 8'h00;
         level_valid    <= 1'b0;
         clap_pulse     <= 1'b0;
         holdoff_active <= 1'b0;
      end else begin
         read_audio_in <= 1'b0;
         level_valid   <= 1'b0;
         clap_pulse    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!enable) begin
                  running_peak <= '0;
                  sample_cnt   <= '0;
               end else if (audio_in_available) begin
                  read_audio_in <= 1'b1;
                  state         <= ST_READ;
               end
            end
            ST_READ: begin
               // The pop is already committed; a disable seen here only
               // marks the sample for discard.
               drop_sample <= !enable;
               state       <= ST_PROC;
            end
            ST_PROC: begin
               if (!enable || drop_sample) begin
                  running_peak <= '0;
                  sample_cnt   <= '0;
                  state        <= ST_IDLE;
               end else if (sample_cnt == LAST_CNT) begin
                  running_peak <= new_peak;
                  peak_level   <= new_level;
                  level_valid  <= 1'b1;
                  state        <= ST_PUBLISH;
                  if (new_level >= THRESHOLD && holdoff == '0) begin
                     clap_pulse     <= 1'b1;
                     holdoff        <= HOLD_LOAD;
                     holdoff_active <= (HOLD_LOAD != '0);
                  end else if (holdoff != '0) begin
                     holdoff        <= holdoff - 1'b1;
                     holdoff_active <= (holdoff != HOLD_W'(1));
                  end
               end else begin
                  running_peak <= new_peak;
                  sample_cnt   <= sample_cnt + 1'b1;
                  state        <= ST_IDLE;
               end
            end
            ST_PUBLISH: begin
               running_peak <= '0;
               sample_cnt   <= '0;
               state        <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_audio_in_level_reader.sv
// ---------------------------------------------------------------------------
// tb_audio_in_level_reader : directed self-checking bench for the level reader
// Revision                 : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_audio_in_level_reader;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic        audio_in_available;
   logic [31:0] left_in;
   logic [31:0] right_in;
   logic        read_audio_in;
   logic [7:0]  peak_level;
   logic        level_valid;
   logic        clap_pulse;
   logic        holdoff_active;

   int n_pass   = 0;
   int n_total  = 0;
   int lv_count = 0;

   localparam logic [19:0] READ_MASK = 20'b0010_0100_0100_1001_0010;
   localparam logic [19:0] LV_MASK   = 20'b0000_0001_0000_0000_0000;

   audio_in_level_reader #(
      .AUDIO_DATA_WIDTH (32),
      .WINDOW_SAMPLES   (4),
      .THRESHOLD        (8'h40),
      .HOLDOFF_WINDOWS  (2)
   ) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .enable             (enable),
      .audio_in_available (audio_in_available),
      .left_in            (left_in),
      .right_in           (right_in),
      .read_audio_in      (read_audio_in),
      .peak_level         (peak_level),
      .level_valid        (level_valid),
      .clap_pulse         (clap_pulse),
      .holdoff_active     (holdoff_active)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (level_valid === 1'b1) lv_count++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".read"},  32'(read_audio_in),  32'd0);
      chk({tag, ".level"}, 32'(peak_level),     32'd0);
      chk({tag, ".valid"}, 32'(level_valid),    32'd0);
      chk({tag, ".clap"},  32'(clap_pulse),     32'd0);
      chk({tag, ".hold"},  32'(holdoff_active), 32'd0);
   endtask

   task automatic wait_read(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(posedge clk); #1;
         if (read_audio_in === 1'b1) seen = 1'b1;
      end
      chk({tag, ".read_seen"}, 32'(seen), 32'd1);
   endtask

   // Offers one sample pair and returns just after the pop edge.
   task automatic send_sample(input logic [31:0] l, input logic [31:0] r);
      audio_in_available = 1'b1;
      left_in            = l;
      right_in           = r;
      wait_read("send");
      @(posedge clk); #1;
      audio_in_available = 1'b0;
   endtask

   task automatic send_window(input logic [31:0] s0, input logic [31:0] s1,
                              input logic [31:0] s2, input logic [31:0] s3);
      send_sample(s0, 32'd0);
      send_sample(s1, 32'd0);
      send_sample(s2, 32'd0);
      send_sample(s3, 32'd0);
   endtask

   task automatic expect_publish(input string tag, input logic [7:0] lvl,
                                 input logic clap, input logic hold);
      @(posedge clk); #1;
      chk({tag, ".valid"}, 32'(level_valid),    32'd1);
      chk({tag, ".level"}, 32'(peak_level),     32'(lvl));
      chk({tag, ".clap"},  32'(clap_pulse),     32'(clap));
      chk({tag, ".hold"},  32'(holdoff_active), 32'(hold));
      @(posedge clk); #1;
      chk({tag, ".valid_end"}, 32'(level_valid), 32'd0);
      chk({tag, ".clap_end"},  32'(clap_pulse),  32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      audio_in_available = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      int base;
      reset_n            = 1'b0;
      enable             = 1'b1;
      audio_in_available = 1'b0;
      left_in            = 32'd0;
      right_in           = 32'd0;

      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      @(negedge clk);
      reset_n = 1'b1;

      // Handshake cadence with availability held high
      audio_in_available = 1'b1;
      for (int k = 1; k <= 19; k++) begin
         @(posedge clk); #1;
         chk($sformatf("hs.read[%0d]", k), 32'(read_audio_in), 32'(READ_MASK[k]));
         chk($sformatf("hs.valid[%0d]", k), 32'(level_valid), 32'(LV_MASK[k]));
      end
      audio_in_available = 1'b0;
      do_reset();

      // Most negative sample saturates to full scale
      base = lv_count;
      send_window(32'd5, 32'h8000_0000, 32'd3, 32'd0);
      expect_publish("sat", 8'hFF, 1'b1, 1'b1);
      chk("sat.one_valid", 32'(lv_count - base), 32'd1);
      do_reset();

      // Threshold: negative right channel loud, then a quiet window
      send_sample(32'd0, 32'hC100_0000);
      send_sample(32'd0, 32'd0);
      send_sample(32'd0, 32'd0);
      send_sample(32'd0, 32'd0);
      expect_publish("thr_loud", 8'h7E, 1'b1, 1'b1);
      send_window(32'h1F00_0000, 32'd0, 32'd0, 32'd0);
      expect_publish("thr_quiet", 8'h3E, 1'b0, 1'b1);
      do_reset();

      // Holdoff across four loud windows
      send_window(32'h3F00_0000, 32'd0, 32'd0, 32'd0);
      expect_publish("hold_w1", 8'h7E, 1'b1, 1'b1);
      send_sample(32'h3F00_0000, 32'd0);
      chk("hold_w2_mid", 32'(holdoff_active), 32'd1);
      send_sample(32'd0, 32'd0);
      send_sample(32'd0, 32'd0);
      send_sample(32'd0, 32'd0);
      expect_publish("hold_w2", 8'h7E, 1'b0, 1'b1);
      send_window(32'h3F00_0000, 32'd0, 32'd0, 32'd0);
      expect_publish("hold_w3", 8'h7E, 1'b0, 1'b0);
      send_window(32'h3F00_0000, 32'd0, 32'd0, 32'd0);
      expect_publish("hold_w4", 8'h7E, 1'b1, 1'b1);

      // Enable drop discards the partial loud window
      send_sample(32'h7F00_0000, 32'd0);
      send_sample(32'h7F00_0000, 32'd0);
      enable             = 1'b0;
      audio_in_available = 1'b1;
      left_in            = 32'h7F00_0000;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk($sformatf("dis.read[%0d]", k), 32'(read_audio_in), 32'd0);
         chk($sformatf("dis.valid[%0d]", k), 32'(level_valid), 32'd0);
      end
      chk("dis.level_kept", 32'(peak_level), 32'h7E);
      chk("dis.hold_kept", 32'(holdoff_active), 32'd1);
      enable = 1'b1;
      send_window(32'h1F00_0000, 32'd0, 32'd0, 32'd0);
      expect_publish("en_quiet", 8'h3E, 1'b0, 1'b1);

      // Asynchronous reset in the middle of a pop
      do_reset();
      send_sample(32'h3F00_0000, 32'd0);
      send_sample(32'h3F00_0000, 32'd0);
      send_sample(32'h3F00_0000, 32'd0);
      audio_in_available = 1'b1;
      left_in            = 32'h3F00_0000;
      wait_read("rst_mid");
      reset_n = 1'b0;
      #1;
      chk_reset_outputs("rst_async");
      audio_in_available = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      base = lv_count;
      send_window(32'h1F00_0000, 32'd0, 32'd0, 32'd0);
      expect_publish("rst_new", 8'h3E, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_one_valid", 32'(lv_count - base), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/audio_in_level_reader.md
# audio_in_level_reader

Receive-side counterpart to the tone writer. It drains captured line-in samples from the audio controller's ADC FIFO using the `audio_in_available` / `read_audio_in` handshake. It reduces each fixed-length window of samples to an 8-bit peak level, and emits a one-cycle `clap_pulse` when that level crosses a threshold. It sits beside the tone writer on the 50 MHz audio clock domain and feeds level/trigger information to the trading core and VGA overlay.

## Interface
- `AUDIO_DATA_WIDTH`, 32: sample width per channel, two's complement.
- `WINDOW_SAMPLES`, 4800: sample pairs per window (100 ms at 48 kHz); ≥2.
- `THRESHOLD`, 8'h40: minimum `peak_level` that fires `clap_pulse`.
- `HOLDOFF_WINDOWS`, 2: windows after a clap during which `clap_pulse` is suppressed.
- `clk`  in  1  system clock (CLOCK_50).
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  1 = consume samples; 0 = stop reading, clear window.
- `audio_in_available`  in  1  ADC FIFO holds ≥1 sample pair; data on `left_in`/`right_in` valid while high.
- `left_in`  in  AUDIO_DATA_WIDTH  left ADC sample.
- `right_in`  in  AUDIO_DATA_WIDTH  right ADC sample.
- `read_audio_in`  out  1  pop strobe, one cycle per sample pair.
- `peak_level`  out  8  peak magnitude of last completed window.
- `level_valid`  out  1  one-cycle strobe, `peak_level` just updated.
- `clap_pulse`  out  1  one-cycle trigger.
- `holdoff_active`  out  1  holdoff counter nonzero.

## Operation
- FSM states: IDLE, READ, PROC, PUBLISH.
- IDLE → READ when `enable && audio_in_available`.
- READ asserts `read_audio_in` for exactly one cycle and captures `left_in`/`right_in` at that edge. It always moves to PROC.
- PROC computes |L| and |R|, takes m = max(|L|,|R|), and sets running_peak = max(running_peak, m). It then increments sample_cnt.
- PROC → PUBLISH if sample_cnt was WINDOW_SAMPLES−1, else → IDLE.
- PUBLISH runs for one cycle:
  - Loads `peak_level` = running_peak[W−2 -: 8], the top 8 magnitude bits.
  - Pulses `level_valid`.
  - Clears running_peak and sample_cnt.
  - Returns to IDLE.
- Clap rule at PUBLISH:
  - If new `peak_level` ≥ THRESHOLD and holdoff = 0: `clap_pulse` = 1 in the same cycle as `level_valid`, and holdoff loads HOLDOFF_WINDOWS.
  - Else, if holdoff ≠ 0, holdoff decrements by 1.
- Absolute value: the most negative input (100…0) saturates to 2^(W−1)−1. No wrap to negative is permitted.
- sample_cnt width is clog2(WINDOW_SAMPLES). It never exceeds WINDOW_SAMPLES−1.
- `enable` low:
  - In IDLE: no read is issued.
  - In READ/PROC: the current sample completes and is discarded.
  - The FSM returns to IDLE and clears running_peak and sample_cnt.
  - `peak_level` and holdoff keep their values; no `level_valid` is produced.
- A pop is never issued while `audio_in_available` is low. The availability value sampled in IDLE governs the transition.

## Timing
- Reset values: `read_audio_in`=0, `peak_level`=0, `level_valid`=0, `clap_pulse`=0, `holdoff_active`=0. FSM=IDLE, counters 0.
- Reset asserted mid-window or mid-handshake: all outputs go to reset values asynchronously, and any partial window is lost.
- Minimum of 3 cycles per sample pair (IDLE, READ, PROC). The last sample of a window adds 1 cycle (PUBLISH).
- With `audio_in_available` held high: `read_audio_in` pulses every 3rd cycle, and every 4th cycle on the last sample of each window.
- `level_valid`/`clap_pulse` occur 2 cycles after the `read_audio_in` cycle of the window's last sample.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Shared package `audio_pkg`:
  - State enum.
  - Default AUDIO_DATA_WIDTH.
  - The abs-with-saturation function, so the tone writer and any meter reuse it.
- One sub-module: `abs_max2`, which maps (L, R) to max(|L|,|R|) with saturation, registered into PROC.
- Top-level: FSM, window counter, holdoff counter.

## Test plan
Bench parameters: WINDOW_SAMPLES=4, W=32, THRESHOLD=8'h40, HOLDOFF_WINDOWS=2.
- **Handshake:** hold `audio_in_available`=1 for 20 cycles → `read_audio_in` high on cycles 1,4,7,10,14,17 (4-cycle gap after each window end). Never two consecutive cycles.
- **Saturation/peak:** window samples L = {5, −0x8000_0000, 3, 0}, R = 0 → `peak_level`=8'hFF, `level_valid` 2 cycles after the 4th read.
- **Threshold:** window peak 0x3F00_0000 → `peak_level`=8'h7E, `clap_pulse`=1. Next window peak 0x1F00_0000 → `peak_level`=8'h3E, no clap.
- **Holdoff:** three consecutive loud windows (8'h7E) → clap on window 1 only, `holdoff_active` high through window 2. Window 4 (loud) → clap again (holdoff 2→1→0 by end of windows 2/3).
- **Enable drop:** 2 samples of peak 0x7F00_0000, `enable` low 5 cycles, then 4 quiet samples → `peak_level`=quiet value. No read while disabled; earlier samples were discarded.
- **Reset mid-window:** `reset_n` low after 3 samples → all outputs 0 immediately. 4 new samples → exactly one `level_valid`.
